// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/wb,
// drives datapath strobes and muxes, traps on overflow and illegal ops.
//
// Ports: clk, rst_n (async active-low)
//   i_opcode/i_funct  : IR fields
//   i_zero/i_ovf      : ALU flags
//   i_mem_ready       : memory completes current access
//   o_alu_sel         : ALU operation
//   o_alu_src_a/b     : ALU operand muxes
//   o_imm_zext        : zero-extend immediate
//   o_pc_src/o_pc_we  : PC mux and write enable
//   o_iord            : memory address select
//   o_mem_rd/o_mem_we : memory strobes
//   o_ir_we/o_reg_we  : IR / regfile write enables
//   o_reg_dst         : rd vs rt
//   o_mem_to_reg      : MDR vs ALUOut
//   o_exc_ovf/o_exc_ill : trap pulses
package mips_sc_definitions_pkg;
  typedef enum logic [3:0] {
    ADD_ALU_Sel  = 4'd0,
    SUB_ALU_Sel  = 4'd1,
    AND_ALU_Sel  = 4'd2,
    OR_ALU_Sel   = 4'd3,
    XOR_ALU_Sel  = 4'd4,
    SLL_ALU_Sel  = 4'd5,
    SRL_ALU_Sel  = 4'd6,
    SLLV_ALU_Sel = 4'd7,
    SRLV_ALU_Sel = 4'd8,
    SRAV_ALU_Sel = 4'd9
  } alu_sel_t;
endpackage

module mips_mc_control
  import mips_sc_definitions_pkg::*;
#(
  parameter bit EXC_ON_OVF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_ovf,
  input  logic       i_mem_ready,
  output alu_sel_t   o_alu_sel,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_imm_zext,
  output logic [1:0] o_pc_src,
  output logic       o_pc_we,
  output logic       o_iord,
  output logic       o_mem_rd,
  output logic       o_mem_we,
  output logic       o_ir_we,
  output logic       o_reg_we,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_exc_ovf,
  output logic       o_exc_ill
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DEC   = 4'd1,
    S_REX   = 4'd2,
    S_RWB   = 4'd3,
    S_IEX   = 4'd4,
    S_IWB   = 4'd5,
    S_MADR  = 4'd6,
    S_MRD   = 4'd7,
    S_MWB   = 4'd8,
    S_MWR   = 4'd9,
    S_BR    = 4'd10,
    S_JMP   = 4'd11,
    S_ILL   = 4'd12,
    S_EOVF  = 4'd13
  } state_t;

  state_t   r_state;
  state_t   w_nxt;
  logic     r_ovf_q;
  alu_sel_t w_r_sel;
  logic     w_r_legal;
  alu_sel_t w_i_sel;
  logic     w_is_r;
  logic     w_is_mem;
  logic     w_is_br;
  logic     w_is_imm;
  logic     w_is_j;
  logic     w_r_ovf_op;

  assign w_is_r   = (i_opcode == 6'h00);
  assign w_is_mem = (i_opcode == 6'h23) |
                    (i_opcode == 6'h2B);
  assign w_is_br  = (i_opcode == 6'h04) |
                    (i_opcode == 6'h05);
  assign w_is_imm = (i_opcode == 6'h08) |
                    (i_opcode == 6'h0C) |
                    (i_opcode == 6'h0D) |
                    (i_opcode == 6'h0E);
  assign w_is_j   = (i_opcode == 6'h02);

  assign w_r_ovf_op = (w_r_sel == ADD_ALU_Sel) |
                      (w_r_sel == SUB_ALU_Sel);

  always_comb begin
    w_r_sel   = ADD_ALU_Sel;
    w_r_legal = 1'b1;
    case (i_funct)
      6'h20:   w_r_sel = ADD_ALU_Sel;
      6'h22:   w_r_sel = SUB_ALU_Sel;
      6'h24:   w_r_sel = AND_ALU_Sel;
      6'h25:   w_r_sel = OR_ALU_Sel;
      6'h26:   w_r_sel = XOR_ALU_Sel;
      6'h00:   w_r_sel = SLL_ALU_Sel;
      6'h02:   w_r_sel = SRL_ALU_Sel;
      6'h04:   w_r_sel = SLLV_ALU_Sel;
      6'h06:   w_r_sel = SRLV_ALU_Sel;
      6'h07:   w_r_sel = SRAV_ALU_Sel;
      default: w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_i_sel = ADD_ALU_Sel;
    case (i_opcode)
      6'h0C:   w_i_sel = AND_ALU_Sel;
      6'h0D:   w_i_sel = OR_ALU_Sel;
      6'h0E:   w_i_sel = XOR_ALU_Sel;
      default: w_i_sel = ADD_ALU_Sel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ovf_q <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_REX:
          r_ovf_q <= EXC_ON_OVF & i_ovf & w_r_ovf_op;
        S_IEX:
          r_ovf_q <= EXC_ON_OVF & i_ovf &
                     (i_opcode == 6'h08);
        S_EOVF:
          r_ovf_q <= 1'b0;
        default:
          r_ovf_q <= r_ovf_q;
      endcase
    end
  end

  always_comb begin
    w_nxt = S_FETCH;
    case (r_state)
      S_FETCH:
        w_nxt = i_mem_ready ? S_DEC : S_FETCH;
      S_DEC: begin
        unique case (1'b1)
          w_is_r:
            w_nxt = w_r_legal ? S_REX : S_ILL;
          w_is_mem: w_nxt = S_MADR;
          w_is_br:  w_nxt = S_BR;
          w_is_imm: w_nxt = S_IEX;
          w_is_j:   w_nxt = S_JMP;
          default:  w_nxt = S_ILL;
        endcase
      end
      S_REX:  w_nxt = S_RWB;
      S_RWB:  w_nxt = r_ovf_q ? S_EOVF : S_FETCH;
      S_IEX:  w_nxt = S_IWB;
      S_IWB:  w_nxt = r_ovf_q ? S_EOVF : S_FETCH;
      S_MADR:
        w_nxt = (i_opcode == 6'h23) ? S_MRD : S_MWR;
      S_MRD:
        w_nxt = i_mem_ready ? S_MWB : S_MRD;
      S_MWB:  w_nxt = S_FETCH;
      S_MWR:
        w_nxt = i_mem_ready ? S_FETCH : S_MWR;
      default: w_nxt = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so strobes drop the moment reset asserts.
  always_comb begin
    o_alu_sel    = ADD_ALU_Sel;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_imm_zext   = 1'b0;
    o_pc_src     = 2'd0;
    o_pc_we      = 1'b0;
    o_iord       = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_exc_ovf    = 1'b0;
    o_exc_ill    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          o_mem_rd    = 1'b1;
          o_alu_src_b = 2'd1;
          o_ir_we     = i_mem_ready;
          o_pc_we     = i_mem_ready;
        end
        S_DEC: o_alu_src_b = 2'd3;
        S_REX: begin
          o_alu_src_a = 1'b1;
          o_alu_sel   = w_r_sel;
        end
        S_RWB: begin
          o_reg_dst = 1'b1;
          o_reg_we  = ~r_ovf_q;
        end
        S_IEX: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'd2;
          o_imm_zext  = (i_opcode != 6'h08);
          o_alu_sel   = w_i_sel;
        end
        S_IWB: o_reg_we = ~r_ovf_q;
        S_MADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'd2;
        end
        S_MRD: begin
          o_mem_rd = 1'b1;
          o_iord   = 1'b1;
        end
        S_MWB: begin
          o_mem_to_reg = 1'b1;
          o_reg_we     = 1'b1;
        end
        S_MWR: begin
          o_mem_we = 1'b1;
          o_iord   = 1'b1;
        end
        S_BR: begin
          o_alu_src_a = 1'b1;
          o_alu_sel   = SUB_ALU_Sel;
          o_pc_src    = 2'd1;
          o_pc_we     = (i_opcode == 6'h04) ?
                        i_zero : ~i_zero;
        end
        S_JMP: begin
          o_pc_src = 2'd2;
          o_pc_we  = 1'b1;
        end
        S_ILL: begin
          o_exc_ill = 1'b1;
          o_pc_src  = 2'd3;
          o_pc_we   = 1'b1;
        end
        S_EOVF: begin
          o_exc_ovf = 1'b1;
          o_pc_src  = 2'd3;
          o_pc_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle expected output
// vectors are queued with the stimulus and compared at negedge.
module tb_mips_mc_control;
  import mips_sc_definitions_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       ovf = 1'b0;
  logic       mem_ready = 1'b0;

  alu_sel_t   alu_sel;
  logic       src_a;
  logic [1:0] src_b;
  logic       zx;
  logic [1:0] pc_src;
  logic       pc_we, iord, mem_rd, mem_we;
  logic       ir_we, reg_we, reg_dst, m2r;
  logic       exc_ovf, exc_ill;

  mips_mc_control #(.EXC_ON_OVF(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_opcode     (opcode),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_ovf        (ovf),
    .i_mem_ready  (mem_ready),
    .o_alu_sel    (alu_sel),
    .o_alu_src_a  (src_a),
    .o_alu_src_b  (src_b),
    .o_imm_zext   (zx),
    .o_pc_src     (pc_src),
    .o_pc_we      (pc_we),
    .o_iord       (iord),
    .o_mem_rd     (mem_rd),
    .o_mem_we     (mem_we),
    .o_ir_we      (ir_we),
    .o_reg_we     (reg_we),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (m2r),
    .o_exc_ovf    (exc_ovf),
    .o_exc_ill    (exc_ill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       sa;
    logic [1:0] sb;
    logic       zx;
    logic [1:0] ps;
    logic       pcwe;
    logic       iord;
    logic       mrd;
    logic       mwe;
    logic       irwe;
    logic       rwe;
    logic       rdst;
    logic       m2r;
    logic       eovf;
    logic       eill;
  } out_t;

  out_t obs;
  assign obs = {alu_sel, src_a, src_b, zx, pc_src,
                pc_we, iord, mem_rd, mem_we, ir_we,
                reg_we, reg_dst, m2r, exc_ovf, exc_ill};

  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic out_t base();
    out_t e;
    e = '0;
    e.sel = ADD_ALU_Sel;
    return e;
  endfunction

  function automatic out_t e_fetch(logic mr);
    out_t e;
    e = base();
    e.sb = 2'd1;
    e.mrd = 1'b1;
    e.irwe = mr;
    e.pcwe = mr;
    return e;
  endfunction

  function automatic out_t e_dec();
    out_t e;
    e = base();
    e.sb = 2'd3;
    return e;
  endfunction

  function automatic out_t e_rex(logic [3:0] s);
    out_t e;
    e = base();
    e.sa = 1'b1;
    e.sel = s;
    return e;
  endfunction

  function automatic out_t e_rwb(logic we);
    out_t e;
    e = base();
    e.rdst = 1'b1;
    e.rwe = we;
    return e;
  endfunction

  function automatic out_t e_iex(logic [3:0] s, logic z);
    out_t e;
    e = base();
    e.sa = 1'b1;
    e.sb = 2'd2;
    e.zx = z;
    e.sel = s;
    return e;
  endfunction

  function automatic out_t e_iwb(logic we);
    out_t e;
    e = base();
    e.rwe = we;
    return e;
  endfunction

  function automatic out_t e_madr();
    out_t e;
    e = base();
    e.sa = 1'b1;
    e.sb = 2'd2;
    return e;
  endfunction

  function automatic out_t e_mrd();
    out_t e;
    e = base();
    e.mrd = 1'b1;
    e.iord = 1'b1;
    return e;
  endfunction

  function automatic out_t e_mwb();
    out_t e;
    e = base();
    e.m2r = 1'b1;
    e.rwe = 1'b1;
    return e;
  endfunction

  function automatic out_t e_mwr();
    out_t e;
    e = base();
    e.mwe = 1'b1;
    e.iord = 1'b1;
    return e;
  endfunction

  function automatic out_t e_br(logic we);
    out_t e;
    e = base();
    e.sa = 1'b1;
    e.sel = SUB_ALU_Sel;
    e.ps = 2'd1;
    e.pcwe = we;
    return e;
  endfunction

  function automatic out_t e_trap(logic [1:0] ps,
                                  logic o, logic il);
    out_t e;
    e = base();
    e.ps = ps;
    e.pcwe = 1'b1;
    e.eovf = o;
    e.eill = il;
    return e;
  endfunction

  task automatic compare();
    out_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             t, obs, e);
    end
  endtask

  task automatic step(input out_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input out_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    compare();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(base(), "reset_idle");
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // add, no overflow
    opcode = 6'h00; funct = 6'h20; ovf = 1'b0;
    step(e_fetch(1'b1), "add_fetch");
    step(e_dec(), "add_dec");
    step(e_rex(ADD_ALU_Sel), "add_ex");
    step(e_rwb(1'b1), "add_wb");

    // add with overflow traps
    step(e_fetch(1'b1), "addv_fetch");
    step(e_dec(), "addv_dec");
    ovf = 1'b1;
    step(e_rex(ADD_ALU_Sel), "addv_ex");
    ovf = 1'b0;
    step(e_rwb(1'b0), "addv_wb");
    step(e_trap(2'd3, 1'b1, 1'b0), "addv_exc");

    // srav, ovf ignored for non-add/sub
    funct = 6'h07;
    step(e_fetch(1'b1), "srav_fetch");
    step(e_dec(), "srav_dec");
    ovf = 1'b1;
    step(e_rex(SRAV_ALU_Sel), "srav_ex");
    ovf = 1'b0;
    step(e_rwb(1'b1), "srav_wb");

    // fetch stall, then illegal funct
    funct = 6'h01;
    mem_ready = 1'b0;
    step(e_fetch(1'b0), "fetch_stall");
    mem_ready = 1'b1;
    step(e_fetch(1'b1), "badf_fetch");
    step(e_dec(), "badf_dec");
    step(e_trap(2'd3, 1'b0, 1'b1), "badf_ill");

    // lw with 3 stall cycles
    opcode = 6'h23;
    step(e_fetch(1'b1), "lw_fetch");
    step(e_dec(), "lw_dec");
    ovf = 1'b1;
    step(e_madr(), "lw_adr");
    ovf = 1'b0;
    mem_ready = 1'b0;
    step(e_mrd(), "lw_rd_s0");
    step(e_mrd(), "lw_rd_s1");
    step(e_mrd(), "lw_rd_s2");
    mem_ready = 1'b1;
    step(e_mrd(), "lw_rd_go");
    step(e_mwb(), "lw_wb");
    step(e_fetch(1'b1), "lw_next_fetch");

    // beq taken (already in FETCH)
    opcode = 6'h04; zero = 1'b1;
    step(e_dec(), "beq_dec");
    step(e_br(1'b1), "beq_br");

    // bne, zero=1 not taken
    opcode = 6'h05;
    step(e_fetch(1'b1), "bne_fetch");
    step(e_dec(), "bne_dec");
    step(e_br(1'b0), "bne_br");
    zero = 1'b0;

    // ori writes even with ovf
    opcode = 6'h0D;
    step(e_fetch(1'b1), "ori_fetch");
    step(e_dec(), "ori_dec");
    ovf = 1'b1;
    step(e_iex(OR_ALU_Sel, 1'b1), "ori_ex");
    ovf = 1'b0;
    step(e_iwb(1'b1), "ori_wb");

    // addi overflow traps
    opcode = 6'h08;
    step(e_fetch(1'b1), "addi_fetch");
    step(e_dec(), "addi_dec");
    ovf = 1'b1;
    step(e_iex(ADD_ALU_Sel, 1'b0), "addi_ex");
    ovf = 1'b0;
    step(e_iwb(1'b0), "addi_wb");
    step(e_trap(2'd3, 1'b1, 1'b0), "addi_exc");

    // jump
    opcode = 6'h02;
    step(e_fetch(1'b1), "j_fetch");
    step(e_dec(), "j_dec");
    step(e_trap(2'd2, 1'b0, 1'b0), "j_jump");

    // illegal opcode
    opcode = 6'h3F;
    step(e_fetch(1'b1), "ill_fetch");
    step(e_dec(), "ill_dec");
    step(e_trap(2'd3, 1'b0, 1'b1), "ill_exc");

    // sw, reset during MEMWR stall
    opcode = 6'h2B;
    step(e_fetch(1'b1), "sw_fetch");
    step(e_dec(), "sw_dec");
    step(e_madr(), "sw_adr");
    mem_ready = 1'b0;
    step(e_mwr(), "sw_wr_s0");
    chk_now(e_mwr(), "sw_wr_hold");
    rst_n = 1'b0;
    chk_now(base(), "sw_rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step(e_fetch(1'b1), "post_rst_fetch");
    step(e_dec(), "post_rst_dec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
